synapse_decoder: RTL and testbench
==================================

// Module: synapse_decoder
// PURPOSE
//  Receive-side synapse for the LIF neuron chain: turns an incoming spike train
//  into a weighted, exponentially decaying 8-bit synaptic current. That current
//  feeds a downstream neuron's current input.
//  Also measures firing rate over fixed windows and hands counts to a consumer
//  over a valid/ready handshake.
// PARAMETERS
//  WINDOW_LEN  16  cycles per rate window (>=2)
//  CNT_W       5   width of the spike/rate counters; 2**CNT_W-1 >= WINDOW_LEN
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous reset, active-high
//  spike_in     in   1      incoming spike, sampled every clk edge
//  weight       in   8      synaptic weight added per spike (unsigned)
//  beta         in   1      decay select: 1 = slow (>>3), 0 = fast (>>1)
//  enable       in   1      1 = rate windows run; 0 = rate counting idle
//  current_out  out  8      registered synaptic current
//  rate_count   out  CNT_W  spikes counted in the last completed window
//  rate_valid   out  1      rate_count holds an unconsumed result
//  rate_ready   in   1      consumer accepts rate_count when rate_valid=1
//  overrun      out  1      sticky: a result was overwritten before being taken
// BEHAVIOUR
//  Reset (rst=1 at an edge): current_out=0, rate_count=0, rate_valid=0,
//   overrun=0, window/spike counters=0, FSM=IDLE. rst overrides all other inputs.
//  Current path (always active, independent of enable):
//   - d = current_out >> (beta ? 3 : 1); if current_out!=0 and d==0 then d=1.
//   - next = (current_out - d) + (spike_in ? weight : 0), saturated at 255.
//   - Latency: spike sampled at edge t changes current_out after edge t.
//  Rate FSM, states IDLE and RUN:
//   - IDLE: counters held at 0. enable=1 at an edge -> RUN; nothing counted
//     on that edge.
//   - RUN, each edge: win_cnt+1; spike_cnt+spike_in, saturating at 2**CNT_W-1.
//   - RUN, edge where win_cnt==WINDOW_LEN-1: rate_count <= spike_cnt+spike_in
//     (saturated); win_cnt, spike_cnt <= 0; rate_valid <= 1.
//   - RUN with enable=0 at an edge -> IDLE. The partial window is discarded.
//     Pending rate_valid and rate_count are kept.
//  Handshake:
//   - Transfer when rate_valid && rate_ready at an edge; rate_valid <= 0.
//   - rate_count is stable while rate_valid=1 unless overrun occurs.
//   - Window completes on the same edge as a transfer: new result loads and
//     rate_valid stays 1. This is not an overrun.
//   - Window completes while rate_valid=1 && !rate_ready: rate_count is
//     overwritten and overrun <= 1. Only rst clears overrun.
//   - rate_ready is ignored while rate_valid=0.
// TESTING
//  1 rst 2 cycles with spike_in=1, weight=50 -> every output 0 while rst held.
//  2 beta=1, weight=100, one spike -> current_out 100, 88, 77, 68, ... reaching 0.
//  3 beta=0, weight=200, one spike -> current_out 200,100,50,25,13,7,4,2,1,0,0.
//  4 beta=1, weight=200, spike on 2 consecutive edges -> current_out 200, then 255.
//  5 enable=1, rate_ready=1, spike every other cycle -> rate_count=8, rate_valid
//    high 1 cycle per 16; all-ones spikes -> rate_count=16.
//  6 rate_ready=0 across 2 windows with 3 then 5 spikes -> rate_count=5, overrun=1.
//    Dropping enable mid-window with 4 spikes counted -> no result emitted;
//    the next full window counts from 0.

Source files
------------

// File: rtl/synapse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : synapse_decoder
// Description : Receive-side synapse. Each incoming spike adds a weight to an
//               8-bit synaptic current, and the current decays exponentially
//               between spikes. In parallel, spikes are counted over fixed
//               windows and each window's count is offered to a consumer on a
//               valid/ready handshake. A sticky flag records any result that
//               was lost because it was replaced before being taken.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_decoder #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_in,
    input  logic [7:0]       weight,
    input  logic             beta,
    input  logic             enable,
    output logic [7:0]       current_out,
    output logic [CNT_W-1:0] rate_count,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] c_win_last = CNT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       r_current;
    logic [7:0]       w_decay;
    logic [7:0]       w_decayed;
    logic [8:0]       w_current_sum;
    logic [7:0]       w_current_next;

    logic [CNT_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_spike_cnt;
    logic [CNT_W-1:0] w_spike_sum;
    logic             w_count_en;
    logic             w_win_done;

    logic [CNT_W-1:0] r_rate_count;
    logic             r_rate_valid;
    logic             r_overrun;

    // Current update: decay by a shift (never stalling above zero), add the
    // weight on a spike, and clamp at full scale.
    always_comb begin
        w_decay = beta ? (r_current >> 3) : (r_current >> 1);
        if ((r_current != 8'd0) && (w_decay == 8'd0)) begin
            w_decay = 8'd1;
        end
        w_decayed      = r_current - w_decay;
        w_current_sum  = {1'b0, w_decayed} + (spike_in ? {1'b0, weight} : 9'd0);
        w_current_next = w_current_sum[8] ? 8'hFF : w_current_sum[7:0];
    end

    // Current register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_current <= 8'd0;
        end else begin
            r_current <= w_current_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and window control; the enabling edge itself counts nothing.
    always_comb begin
        w_state_next = r_state;
        w_count_en   = 1'b0;
        w_win_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_en = 1'b1;
                    w_win_done = (r_win_cnt == c_win_last);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_spike_sum = (r_spike_cnt == c_cnt_max) ? c_cnt_max
                    : r_spike_cnt + {{(CNT_W-1){1'b0}}, spike_in};
    end

    // Window and spike counters; held at zero whenever not counting, which
    // also discards a partial window when enable drops.
    always_ff @(posedge clk) begin
        if (rst || !w_count_en || w_win_done) begin
            r_win_cnt   <= '0;
            r_spike_cnt <= '0;
        end else begin
            r_win_cnt   <= r_win_cnt + 1'b1;
            r_spike_cnt <= w_spike_sum;
        end
    end

    // Result register and handshake; a completing window wins over a
    // same-edge transfer, and replacing an untaken result flags overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate_count <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_win_done) begin
            r_rate_count <= w_spike_sum;
            r_rate_valid <= 1'b1;
            if (r_rate_valid && !rate_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_rate_valid && rate_ready) begin
            r_rate_valid <= 1'b0;
        end
    end

    assign current_out = r_current;
    assign rate_count  = r_rate_count;
    assign rate_valid  = r_rate_valid;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_synapse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_synapse_decoder
// Description : Self-checking bench for synapse_decoder. Directed scenarios
//               plus randomized traffic, all compared against a behavioural
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synapse_decoder;

    localparam int WINDOW_LEN = 16;
    localparam int CNT_W      = 5;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             spike_in;
    logic [7:0]       weight;
    logic             beta;
    logic             enable;
    logic [7:0]       current_out;
    logic [CNT_W-1:0] rate_count;
    logic             rate_valid;
    logic             rate_ready;
    logic             overrun;

    synapse_decoder #(
        .WINDOW_LEN (WINDOW_LEN),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (spike_in),
        .weight      (weight),
        .beta        (beta),
        .enable      (enable),
        .current_out (current_out),
        .rate_count  (rate_count),
        .rate_valid  (rate_valid),
        .rate_ready  (rate_ready),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_cur;
    bit m_run;
    int m_window[$];
    int m_rc;
    bit m_rv;
    bit m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        int  d;
        int  sum;
        bit  done;
        if (rst) begin
            m_cur = 0; m_run = 0; m_window.delete();
            m_rc = 0; m_rv = 0; m_ov = 0;
            return;
        end
        d = beta ? m_cur / 8 : m_cur / 2;
        if (m_cur != 0 && d == 0) d = 1;
        m_cur = m_cur - d + (spike_in ? int'(weight) : 0);
        if (m_cur > 255) m_cur = 255;

        done = 0;
        if (!m_run) begin
            if (enable) m_run = 1;
        end else if (!enable) begin
            m_run = 0;
            m_window.delete();
        end else begin
            m_window.push_back(int'(spike_in));
            if (m_window.size() == WINDOW_LEN) begin
                sum = 0;
                foreach (m_window[i]) sum += m_window[i];
                if (sum > CNT_MAX) sum = CNT_MAX;
                if (m_rv && !rate_ready) m_ov = 1;
                m_rc = sum;
                m_rv = 1;
                done = 1;
                m_window.delete();
            end
        end
        if (!done && m_rv && rate_ready) m_rv = 0;
    endtask

    // One clock: update model, take the edge, compare every output.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("current_out", 32'(current_out), 32'(m_cur));
        check("rate_count",  32'(rate_count),  32'(m_rc));
        check("rate_valid",  32'(rate_valid),  32'(m_rv));
        check("overrun",     32'(overrun),     32'(m_ov));
    endtask

    int exp_fast[11] = '{200, 100, 50, 25, 13, 7, 4, 2, 1, 0, 0};
    int spikes_seen;
    int last_rc;

    initial begin
        m_cur = 0; m_run = 0; m_rc = 0; m_rv = 0; m_ov = 0;
        rst = 1'b1; spike_in = 1'b1; weight = 8'd50; beta = 1'b0;
        enable = 1'b1; rate_ready = 1'b1;

        // Reset held with active inputs: everything stays zero
        repeat (2) begin
            tick();
            check("rst_current", 32'(current_out), 32'd0);
            check("rst_valid",   32'(rate_valid),  32'd0);
        end
        rst = 1'b0; spike_in = 1'b0; enable = 1'b0;
        tick();

        // Slow decay from a single spike
        beta = 1'b1; weight = 8'd100; spike_in = 1'b1;
        tick();
        check("slow_first", 32'(current_out), 32'd100);
        spike_in = 1'b0;
        tick();
        check("slow_second", 32'(current_out), 32'd88);
        tick();
        check("slow_third", 32'(current_out), 32'd77);
        repeat (50) tick();
        check("slow_zero", 32'(current_out), 32'd0);

        // Fast decay from a single spike
        beta = 1'b0; weight = 8'd200; spike_in = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            spike_in = 1'b0;
            check("fast_seq", 32'(current_out), 32'(exp_fast[i]));
        end

        // Saturation on back-to-back spikes
        beta = 1'b1; weight = 8'd200; spike_in = 1'b1;
        tick();
        check("sat_first", 32'(current_out), 32'd200);
        tick();
        check("sat_second", 32'(current_out), 32'd255);
        spike_in = 1'b0;
        repeat (40) tick();

        // Rate: spike every other cycle, consumer always ready
        enable = 1'b1; rate_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            spike_in = i[0];
            tick();
            if (rate_valid) check("rate_alt", 32'(rate_count), 32'd8);
        end
        // All-ones spikes
        spike_in = 1'b1;
        last_rc = -1;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (rate_valid) last_rc = int'(rate_count);
        end
        check("rate_full", 32'(last_rc), 32'd16);

        // Overrun: two windows of 3 then 5 spikes with consumer stalled
        enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b1;
        repeat (2) tick();
        enable = 1'b1; rate_ready = 1'b0;
        tick();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
                spike_in = (i < ((w == 0) ? 3 : 5));
                tick();
            end
        end
        spike_in = 1'b0;
        check("ovr_count", 32'(rate_count), 32'd5);
        check("ovr_flag",  32'(overrun),    32'd1);
        check("ovr_valid", 32'(rate_valid), 32'd1);

        // Enable dropped mid-window: partial window discarded
        enable = 1'b0; rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            spike_in = i[0];
            tick();
        end
        spike_in = 1'b0; enable = 1'b0;
        tick();
        repeat (20) tick();
        check("drop_novalid", 32'(rate_valid), 32'd0);
        enable = 1'b1;
        tick();
        for (int i = 0; i < WINDOW_LEN; i++) begin
            spike_in = (i == 3) || (i == 9);
            tick();
        end
        spike_in = 1'b0;
        check("drop_fresh", 32'(rate_count), 32'd2);
        check("drop_valid", 32'(rate_valid), 32'd1);

        // Randomized traffic
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spikes_seen = 0;
        for (int i = 0; i < 2500; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            spike_in   = ($urandom_range(0, 2) != 0);
            weight     = 8'($urandom_range(0, 255));
            beta       = 1'($urandom);
            enable     = ($urandom_range(0, 31) != 0);
            rate_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
